cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor for the MIPS_Archi datapath, generalising the existing combinational 8-bit CLA to WIDTH bits. It uses one registered pipeline stage per GROUP_W-bit lookahead group, with the carry passing between stages through registers. A valid/ready handshake on both sides sustains one operation per cycle, with back-pressure. It adds a subtract mode and a signed-overflow flag, and keeps the full-width group propagate/generate outputs for hierarchical lookahead.

---
 rtl/cla_pkg.sv | 39 +++
 rtl/cla_group.sv | 45 ++++
 rtl/cla_pipe_adder.sv | 127 ++++++++++++
 tb/tb_cla_pipe_adder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared group width, P/G types and lookahead helpers for the pipelined CLA
package cla_pkg;

  localparam int CLA_GROUP_W = 8;
  // Widest lookahead group the helpers handle; narrower groups pad the upper lanes.
  localparam int CLA_MAX_GW  = 32;

  typedef logic [CLA_MAX_GW-1:0] grp_vec_t;

  typedef struct packed {
    grp_vec_t p;
    grp_vec_t g;
  } pg_vec_t;

  typedef struct packed {
    logic p;
    logic g;
  } blk_pg_t;

  function automatic pg_vec_t p_g(input grp_vec_t a, input grp_vec_t b);
    pg_vec_t r;
    r.p = a ^ b;
    r.g = a & b;
    return r;
  endfunction

  // Lanes padded with P=1, G=0 are transparent, so callers can mask any prefix.
  function automatic blk_pg_t blk_pg(input grp_vec_t p, input grp_vec_t g);
    blk_pg_t r;
    r.p = 1'b1;
    r.g = 1'b0;
    for (int i = 0; i < CLA_MAX_GW; i++) begin
      r.g = g[i] | (p[i] & r.g);
      r.p = r.p & p[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational GROUP_W-bit lookahead group with carry into its MSB exposed
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP_W = CLA_GROUP_W
) (
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               c_in,
  output logic [GROUP_W-1:0] s,
  output logic               c_out,
  output logic               c_msb_in,
  output logic               pg,
  output logic               gg
);

  localparam grp_vec_t LANES = grp_vec_t'({GROUP_W{1'b1}});

  pg_vec_t          v;
  grp_vec_t         m;
  blk_pg_t          pre;
  blk_pg_t          all;
  logic [GROUP_W:0] c;

  // Each carry is the prefix group generate/propagate over bits below it.
  always_comb begin
    v    = p_g(grp_vec_t'(a), grp_vec_t'(b));
    m    = '0;
    pre  = '0;
    c    = '0;
    c[0] = c_in;
    for (int i = 0; i < GROUP_W; i++) begin
      m[i]     = 1'b1;
      pre      = blk_pg(v.p | ~m, v.g & m);
      c[i+1]   = pre.g | (pre.p & c_in);
    end
    all      = blk_pg(v.p | ~LANES, v.g & LANES);
    s        = v.p[GROUP_W-1:0] ^ c[GROUP_W-1:0];
    c_out    = c[GROUP_W];
    c_msb_in = c[GROUP_W-1];
    pg       = all.p;
    gg       = all.g;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined add/sub CLA, one registered stage per lookahead group
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int GROUP_W = CLA_GROUP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             pg,
  output logic             gg
);

  localparam int NGROUPS = WIDTH / GROUP_W;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  logic             v_r  [NGROUPS];
  logic [WIDTH-1:0] a_r  [NGROUPS];
  logic [WIDTH-1:0] b_r  [NGROUPS];
  logic [WIDTH-1:0] s_r  [NGROUPS];
  logic             c_r  [NGROUPS];
  logic             cm_r [NGROUPS];
  logic             pg_r [NGROUPS];
  logic             gg_r [NGROUPS];

  // A single global advance keeps every stage in lockstep; a stalled output freezes the pipe.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = b ^ {WIDTH{sub}};
  assign c_eff    = sub | cin;

  for (genvar k = 0; k < NGROUPS; k++) begin : g_stage
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic [WIDTH-1:0]   s_in;
    logic [WIDTH-1:0]   s_nxt;
    logic               v_in;
    logic               c_in_k;
    logic               pg_in;
    logic               gg_in;
    logic [GROUP_W-1:0] s_grp;
    logic               c_out_k;
    logic               c_msb_k;
    logic               p_k;
    logic               g_k;

    if (k == 0) begin : g_first
      assign a_in   = a;
      assign b_in   = b_eff;
      assign s_in   = '0;
      assign v_in   = in_valid;
      assign c_in_k = c_eff;
      assign pg_in  = 1'b1;
      assign gg_in  = 1'b0;
    end else begin : g_next
      assign a_in   = a_r[k-1];
      assign b_in   = b_r[k-1];
      assign s_in   = s_r[k-1];
      assign v_in   = v_r[k-1];
      assign c_in_k = c_r[k-1];
      assign pg_in  = pg_r[k-1];
      assign gg_in  = gg_r[k-1];
    end

    cla_group #(
      .GROUP_W (GROUP_W)
    ) u_grp (
      .a        (a_in[k*GROUP_W +: GROUP_W]),
      .b        (b_in[k*GROUP_W +: GROUP_W]),
      .c_in     (c_in_k),
      .s        (s_grp),
      .c_out    (c_out_k),
      .c_msb_in (c_msb_k),
      .pg       (p_k),
      .gg       (g_k)
    );

    always_comb begin
      s_nxt                        = s_in;
      s_nxt[k*GROUP_W +: GROUP_W]  = s_grp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r[k]  <= 1'b0;
        a_r[k]  <= '0;
        b_r[k]  <= '0;
        s_r[k]  <= '0;
        c_r[k]  <= 1'b0;
        cm_r[k] <= 1'b0;
        pg_r[k] <= 1'b0;
        gg_r[k] <= 1'b0;
      end else if (adv) begin
        v_r[k]  <= v_in;
        a_r[k]  <= a_in;
        b_r[k]  <= b_in;
        s_r[k]  <= s_nxt;
        c_r[k]  <= c_out_k;
        cm_r[k] <= c_msb_k;
        pg_r[k] <= pg_in & p_k;
        gg_r[k] <= g_k | (p_k & gg_in);
      end
    end
  end

  assign out_valid = v_r[NGROUPS-1];
  assign sum       = s_r[NGROUPS-1];
  assign cout      = c_r[NGROUPS-1];
  assign ovf       = cm_r[NGROUPS-1] ^ c_r[NGROUPS-1];
  assign pg        = pg_r[NGROUPS-1];
  assign gg        = gg_r[NGROUPS-1];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - scoreboard bench for cla_pipe_adder with directed vectors
module tb_cla_pipe_adder;

  localparam int W   = 32;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         pg;
  logic         gg;

  cla_pipe_adder #(.WIDTH(W), .GROUP_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .pg        (pg),
    .gg        (gg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic [3:0]  f;   // {cout, ovf, pg, gg}
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          seen_idle = 0;
  bit          idle_watch = 1'b0;
  int          stall_n;
  int          drain_n;
  logic [31:0] hold_sum;
  logic [3:0]  hold_f;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation for every handshaked result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (idle_watch) seen_idle++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got sum %h want no result", sum);
      end else begin
        mon_e = sb.pop_front();
        chk("sum", sum, mon_e.s);
        chk("flags{cout,ovf,pg,gg}", 32'({cout, ovf, pg, gg}), 32'(mon_e.f));
        if (mon_e.lat) chk("latency", 32'(cyc - mon_e.acc), 32'(LAT));
      end
    end
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                      input logic ts, input logic [31:0] es, input logic [3:0] ef, input bit lat);
    bit acc;
    int n;
    int ac;
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    acc = 1'b0; n = 0; ac = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      ac  = cyc;
      n++;
      @(posedge clk);
      if (acc) sb.push_back('{s: es, f: ef, acc: ac, lat: lat});
      #1;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready 0 for %0d cycles want 1", n);
    end
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with a live request on the input.
    in_valid = 1'b1; a = 32'hDEADBEEF; b = 32'h1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_flags", 32'({cout, ovf, pg, gg}), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    send(32'h000000A5, 32'h0000005A, 1'b0, 1'b0, 32'h000000FF, 4'b0000, 1'b1);
    tick(6);
    send(32'hFFFFFFF1, 32'h0000001F, 1'b1, 1'b0, 32'h00000011, 4'b1001, 1'b1);
    tick(6);

    send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 4'b1010, 1'b1);
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 4'b0100, 1'b1);
    send(32'h00000010, 32'h00000001, 1'b0, 1'b1, 32'h0000000F, 4'b1001, 1'b1);
    tick(6);

    // Six back-to-back operations with a three-cycle output stall.
    fork
      begin
        send(32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 4'b0000, 1'b0);
        send(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 4'b1101, 1'b0);
        send(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 4'b0000, 1'b0);
        send(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 4'b0000, 1'b0);
        send(32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0, 32'h00000000, 4'b1010, 1'b0);
        send(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 4'b1101, 1'b0);
      end
      begin
        stall_n = 0;
        while (!out_valid && stall_n < 50) begin
          @(posedge clk); #1;
          stall_n++;
        end
        if (!out_valid) begin
          total++;
          bad++;
          $display("FAIL stall_wait: got out_valid 0 want 1");
        end
        out_ready = 1'b0;
        hold_sum  = sum;
        hold_f    = {cout, ovf, pg, gg};
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_out_valid", 32'(out_valid), 32'd1);
          chk("stall_sum_stable", sum, hold_sum);
          chk("stall_flags_stable", 32'({cout, ovf, pg, gg}), 32'(hold_f));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    tick(10);

    // Three operations in flight when reset hits.
    out_ready = 1'b0;
    send(32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 4'b0000, 1'b0);
    send(32'h00000010, 32'h00000020, 1'b0, 1'b0, 32'h00000030, 4'b0000, 1'b0);
    send(32'h00000100, 32'h00000200, 1'b0, 1'b0, 32'h00000300, 4'b0000, 1'b0);
    tick(1);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", sum, 32'd0);
    sb.delete();
    tick(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle_watch = 1'b1;
    tick(12);
    chk("post_rst_no_output", 32'(seen_idle), 32'd0);
    idle_watch = 1'b0;

    send(32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 4'b0000, 1'b1);

    drain_n = 0;
    while (sb.size() != 0 && drain_n < 100) begin
      @(posedge clk);
      drain_n++;
    end
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d results outstanding want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
